// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 4096-word memory with per-byte write lanes.
// Define MISALIGNED_EN to allow misaligned accesses, split over two words when needed.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_data_in,
  output logic [11:0] mem_address,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [11:0] word0_q, word0_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [6:0]  lanes_q, lanes_d;
  logic [55:0] buf_q, buf_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [11:0] mem_address_q, mem_address_d;

  logic        accept;
  logic        align_err;
  logic        new_err;
  logic [6:0]  new_lanes;
  logic        split;
  logic [6:0]  cap_lanes;
  logic [55:0] buf_merged;
  logic [55:0] assembled;
  logic        unused_ok;

  function automatic logic [6:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [6:0] base;
    case (f3[1:0])
      2'b00:   base = 7'b0000001;
      2'b01:   base = 7'b0000011;
      2'b10:   base = 7'b0001111;
      default: base = 7'b0000000;
    endcase
    lane_mask = base << off;
  endfunction

  function automatic logic funct_error(input logic we, input logic [2:0] f3);
    case (f3)
      3'b011, 3'b110, 3'b111: funct_error = 1'b1;
      default:                funct_error = we & f3[2];
    endcase
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    rotl_bytes = d;
      2'd1:    rotl_bytes = {d[23:0], d[31:24]};
      2'd2:    rotl_bytes = {d[15:0], d[31:16]};
      2'd3:    rotl_bytes = {d[7:0], d[31:8]};
      default: rotl_bytes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  load_extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_extend = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_extend = raw;
      3'b100:  load_extend = {24'd0, raw[7:0]};
      3'b101:  load_extend = {16'd0, raw[15:0]};
      default: load_extend = 32'd0;
    endcase
  endfunction

`ifdef MISALIGNED_EN
  assign align_err = 1'b0;
  assign split     = |lanes_q[6:4];
`else
  assign align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign split     = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_ready = (state_q == IDLE);
  assign unused_ok = ^{req_addr[31:14], assembled[55:32]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = ACC0;
        else           state_d = IDLE;
      end
      ACC0: begin
        if (split) state_d = ACC1;
        else       state_d = RESP;
      end
      ACC1:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load byte assembly; lanes 4..6 arrive from word1 on lanes 0..2.
  always_comb begin
    new_err = funct_error(req_we, req_funct3) | align_err;
    if (new_err) new_lanes = 7'd0;
    else         new_lanes = lane_mask(req_funct3, req_addr[1:0]);

    if (accept) begin
      word0_d = req_addr[13:2];
      off_d   = req_addr[1:0];
      f3_d    = req_funct3;
      we_d    = req_we;
      err_d   = new_err;
      lanes_d = new_lanes;
    end else begin
      word0_d = word0_q;
      off_d   = off_q;
      f3_d    = f3_q;
      we_d    = we_q;
      err_d   = err_q;
      lanes_d = lanes_q;
    end

    cap_lanes = 7'd0;
    case (state_q)
      ACC0: begin
        if (we_q) cap_lanes = 7'd0;
        else      cap_lanes = {3'b000, lanes_q[3:0]};
      end
      ACC1: begin
        if (we_q) cap_lanes = 7'd0;
        else      cap_lanes = {lanes_q[6:4], 4'b0000};
      end
      default: cap_lanes = 7'd0;
    endcase

    for (int i = 0; i < 7; i++) begin
      if (cap_lanes[i]) buf_merged[8*i +: 8] = mem_data_out[8*(i%4) +: 8];
      else              buf_merged[8*i +: 8] = buf_q[8*i +: 8];
    end

    if (accept) buf_d = 56'd0;
    else        buf_d = buf_merged;

    assembled = buf_merged >> {off_q, 3'b000};
  end

  // Outputs are computed for the state being entered so they leave a flop.
  always_comb begin
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = 32'd0;
    mem_en_d      = 1'b0;
    mem_mask_d    = 4'b0000;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    case (state_d)
      ACC0: begin
        mem_address_d = req_addr[13:2];
        mem_data_in_d = rotl_bytes(req_wdata, req_addr[1:0]);
        mem_en_d      = req_we & ~new_err;
        if (req_we) mem_mask_d = new_lanes[3:0];
        else        mem_mask_d = 4'b0000;
      end
      ACC1: begin
        mem_address_d = word0_q + 12'd1;
        mem_en_d      = we_q;
        if (we_q) mem_mask_d = {1'b0, lanes_q[6:4]};
        else      mem_mask_d = 4'b0000;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (we_q || err_q) rsp_rdata_d = 32'd0;
        else               rsp_rdata_d = load_extend(f3_q, assembled[31:0]);
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word0_q       <= 12'd0;
      off_q         <= 2'd0;
      f3_q          <= 3'd0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      lanes_q       <= 7'd0;
      buf_q         <= 56'd0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      mem_en_q      <= 1'b0;
      mem_mask_q    <= 4'b0000;
      mem_data_in_q <= 32'd0;
      mem_address_q <= 12'd0;
    end else begin
      word0_q       <= word0_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      we_q          <= we_d;
      err_q         <= err_d;
      lanes_q       <= lanes_d;
      buf_q         <= buf_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_mask_q    <= mem_mask_d;
      mem_data_in_q <= mem_data_in_d;
      mem_address_q <= mem_address_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_mask    = mem_mask_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_address = mem_address_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have a clk input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-002 The block SHALL have a rst input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have a req_valid input, 1 bit: the core presents a request.
REQ-004 The block SHALL have a req_ready output, 1 bit: the block accepts a request this cycle.
REQ-005 The block SHALL have a req_we input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have a req_funct3 input, 3 bits, using RV32I encodings: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 The block SHALL have a req_addr input, 32 bits: byte address.
REQ-008 The block SHALL have a req_wdata input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have a rsp_valid output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have a rsp_rdata output, 32 bits: load result, extended; 0 for stores and errors.
REQ-011 The block SHALL have a rsp_err output, 1 bit: request rejected; valid with rsp_valid.
REQ-012 The block SHALL have a mem_en output, 1 bit: write enable to the data memory.
REQ-013 The block SHALL have a mem_mask output, 4 bits: byte-lane write mask, where bit i selects bits [8i+7:8i].
REQ-014 The block SHALL have a mem_data_in output, 32 bits: lane-aligned store data.
REQ-015 The block SHALL have a mem_address output, 12 bits: word index.
REQ-016 The block SHALL have a mem_data_out input, 32 bits: combinational read data of the word at mem_address.

Function
REQ-017 The block SHALL use the states IDLE, ACC0, ACC1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 When req_valid=1 in IDLE (accept at cycle T), the block SHALL register the request and go to ACC0.
REQ-019 The first word SHALL be word0 = req_addr[13:2], the byte offset SHALL be off = req_addr[1:0], and the size SHALL be 1, 2 or 4 bytes.
REQ-020 The block SHALL treat the request as covering byte lanes off..off+size-1; lanes 0-3 SHALL map to word0 and lanes 4-6 SHALL map to word1 = word0+1, modulo 4096, so word 4095 wraps to word 0.
REQ-021 In ACC0 the block SHALL drive mem_address=word0 and mem_mask equal to the lanes below 4; in ACC1 it SHALL drive mem_address=word1 and mem_mask equal to the lanes at 4 and above, minus 4.
REQ-022 mem_data_in SHALL equal req_wdata rotated left by 8*off bits, so that each lane carries its own byte.
REQ-023 mem_en SHALL be 1 in ACC0 and ACC1 for stores only; in every other state and for loads, mem_en SHALL be 0 and mem_mask SHALL be 0000.
REQ-024 For loads, the block SHALL capture mem_data_out bytes for the active lanes at the end of each ACC state.
REQ-025 The block SHALL go from ACC0 to ACC1 when the access crosses a word (off+size>4); otherwise it SHALL go from ACC0 to RESP.
REQ-026 The block SHALL go from ACC1 to RESP.
REQ-027 The block SHALL go from RESP to IDLE.
REQ-028 rsp_valid SHALL be 1 only in RESP: at T+2 for single-word accesses and at T+3 for split accesses.
REQ-029 rsp_rdata SHALL hold the assembled bytes in little-endian order; LB/LH SHALL be sign-extended from bit 7/15, and LBU/LHU/LW SHALL be zero-extended.
REQ-030 funct3 011, 110 or 111, and any store with funct3 1xx, SHALL give rsp_err=1 with no memory write, rsp_valid at T+2 and rsp_rdata=0.
REQ-031 A request presented while req_ready=0 SHALL be ignored; the core SHALL hold it until it is accepted.
REQ-032 There is no response backpressure: the core SHALL accept rsp_valid unconditionally.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL enter IDLE and clear rsp_valid, rsp_err, rsp_rdata, mem_en, mem_mask, mem_data_in and mem_address to 0.
REQ-034 Reset SHALL take priority over every transition, including mid-split; an ACC1 write that has not yet been clocked SHALL NOT occur.
REQ-035 req_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-036 The macro MISALIGNED_EN SHALL control misaligned-access support.
REQ-037 With MISALIGNED_EN defined, all non-error accesses at any offset SHALL be performed per REQ-020 to REQ-026.
REQ-038 Without MISALIGNED_EN, a halfword with addr[0]=1 or a word with addr[1:0]!=00 SHALL give rsp_err=1 at T+2 with no memory write and rsp_rdata=0; ACC1 SHALL be unreachable.

Verification
REQ-039 The bench SHALL cover: SW addr 0x100, data 0xDEADBEEF -> at T+1, mem_address=0x040, mask=1111, mem_en=1; rsp_valid at T+2 with err=0.
REQ-040 The bench SHALL cover: SB addr 0x103, data 0x000000AB -> mask=1000, mem_data_in[31:24]=0xAB; a following LB at 0x103 -> rsp_rdata=0xFFFFFFAB, and LBU at 0x103 -> 0x000000AB.
REQ-041 The bench SHALL cover, with MISALIGNED_EN: SW addr 0x0006, data 0x11223344 -> ACC0 word 1 mask=1100, ACC1 word 2 mask=0011; a following LW 0x0006 -> 0x11223344 with rsp_valid at T+3.
REQ-042 The bench SHALL cover, with MISALIGNED_EN: SH addr 0x3FFF, data 0xBEEF -> word 4095 mask=1000 byte 0xEF, then word 0 mask=0001 byte 0xBE.
REQ-043 The bench SHALL cover, without MISALIGNED_EN: LH addr 0x0001 -> rsp_err=1 and rsp_rdata=0 at T+2, with mem_en=0 throughout; and funct3=011 -> rsp_err=1.
REQ-044 The bench SHALL cover: rst asserted during ACC0 of a split SW -> no ACC1 write, IDLE on the next cycle, rsp_valid=0 and the word1 contents unchanged.
